// File: rtl/multi_digit_counter_if.sv
// Control and status bundle for the BCD counter.
// Master drives count controls; slave returns count, segments and wrap.
interface multi_digit_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_bcd;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  wrap;

    modport master (
        output en, up, load, load_bcd,
        input  bcd, seg, wrap
    );

    modport slave (
        input  en, up, load, load_bcd,
        output bcd, seg, wrap
    );
endinterface

// File: rtl/multi_digit_counter.sv
// Prescaled up/down BCD counter with load, wrap pulse and
// 7-segment decode (optional leading-zero blanking).
module multi_digit_counter #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 50,
    parameter bit BLANK_LZ = 1'b0
) (
    input logic                   clkin,
    input logic                   rst,
    multi_digit_counter_if.slave  bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]         pre_q, pre_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  wrap_q, wrap_d;
    logic [4*DIGITS-1:0]   step_val;
    logic [4*DIGITS-1:0]   load_val;
    logic                  carry_top;
    logic                  tick;
    logic [7*DIGITS-1:0]   seg_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        tick = bus.en && (pre_q == PS_LAST);
    end

    // Ripple the carry/borrow through the digits; c out of the top is the wrap.
    always_comb begin
        logic       c;
        logic [3:0] d;
        c        = 1'b1;
        d        = 4'd0;
        step_val = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            d = bcd_q[4*k +: 4];
            if (c) begin
                if (bus.up) begin
                    if (d == 4'd9) begin
                        step_val[4*k +: 4] = 4'd0;
                    end else begin
                        step_val[4*k +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        step_val[4*k +: 4] = 4'd9;
                    end else begin
                        step_val[4*k +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        carry_top = c;
    end

    // Non-decimal load digits collapse to zero so every digit stays 0..9.
    always_comb begin
        load_val = bus.load_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.load_bcd[4*k +: 4] > 4'd9) begin
                load_val[4*k +: 4] = 4'd0;
            end
        end
    end

    always_comb begin
        pre_d  = pre_q;
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bcd_d = load_val;
            pre_d = '0;
        end else if (bus.en) begin
            if (tick) begin
                pre_d  = '0;
                bcd_d  = step_val;
                wrap_d = carry_top;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            bcd_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            bcd_q  <= bcd_d;
            wrap_q <= wrap_d;
        end
    end

    // Scan from the top digit; blank while still inside the leading zeros.
    always_comb begin
        logic lead;
        lead  = BLANK_LZ;
        seg_c = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (lead && (k != 0)) begin
                seg_c[7*k +: 7] = 7'b0000000;
            end else begin
                seg_c[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
            end
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.wrap = wrap_q;
    assign bus.seg  = seg_c;

endmodule
